// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_busy;

  // Adder side: takes operands, presents the result.
  modport slave (
    input  i_valid, i_a, i_b, i_cin, i_ready,
    output o_ready, o_valid, o_sum, o_cout, o_busy
  );

  // Client side: issues operands, consumes the result.
  modport master (
    output i_valid, i_a, i_b, i_cin, i_ready,
    input  o_ready, o_valid, o_sum, o_cout, o_busy
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first,
// with a valid/ready request and result handshake.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  serial_add_ctrl_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic             ha0_s, ha0_c, ha1_s, ha1_c, fa_c;
  logic             last_bit;
  logic [WIDTH:0]   sum_ext;

  // Single full-adder cell built from two half adders and an OR.
  assign ha0_s = a_q[0] ^ b_q[0];
  assign ha0_c = a_q[0] & b_q[0];
  assign ha1_s = ha0_s ^ c_q;
  assign ha1_c = ha0_s & c_q;
  assign fa_c  = ha0_c | ha1_c;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
  assign sum_ext  = {ha1_s, sum_q};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  // Next-state and datapath update selection.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          state_d = RUN;
          a_d     = bus.i_a;
          b_d     = bus.i_b;
          c_d     = bus.i_cin;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_c;
        sum_d = sum_ext[WIDTH:1];
        cnt_d = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
    busy_d  = (state_d == RUN);
  end

  // State, datapath and status-flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // The carry flop holds the final carry once RUN completes.
  assign bus.o_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_sum   = sum_q;
  assign bus.o_cout  = c_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_add_ctrl;

  logic clk;
  logic rst;

  int n_checks;
  int n_errors;

  logic [8:0] q8[$];
  logic [2:0] q2[$];

  serial_add_ctrl_if #(.WIDTH(8)) bus8();
  serial_add_ctrl_if #(.WIDTH(2)) bus2();

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus8)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .reset (rst),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when it mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 request and record the expected result.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    bus8.i_a     = a;
    bus8.i_b     = b;
    bus8.i_cin   = c;
    bus8.i_valid = 1'b1;
    tick();
    bus8.i_valid = 1'b0;
    q8.push_back(9'(a) + 9'(b) + 9'(c));
  endtask

  // Wait for o_valid, compare against the scoreboard, optionally stall, then handshake.
  task automatic collect8(input string tag, input int exp_lat, input int hold);
    int n;
    logic [8:0] exp;
    logic [7:0] s0;
    logic c0;
    n = 0;
    if (!bus8.o_valid) check({tag, "_busy"}, 32'(bus8.o_busy), 32'd1);
    while (!bus8.o_valid && n < 40) begin
      tick();
      n++;
    end
    if (!bus8.o_valid) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, "_lat"}, 32'(n), 32'(exp_lat));
      if (q8.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
        exp = q8.pop_front();
        check({tag, "_sum"}, 32'(bus8.o_sum), 32'(exp[7:0]));
        check({tag, "_cout"}, 32'(bus8.o_cout), 32'(exp[8]));
      end
      s0 = bus8.o_sum;
      c0 = bus8.o_cout;
      for (int i = 0; i < hold; i++) begin
        tick();
        check({tag, "_hold_valid"}, 32'(bus8.o_valid), 32'd1);
        check({tag, "_hold_sum"}, 32'(bus8.o_sum), 32'(s0));
        check({tag, "_hold_cout"}, 32'(bus8.o_cout), 32'(c0));
        check({tag, "_hold_ready"}, 32'(bus8.o_ready), 32'd0);
      end
      bus8.i_ready = 1'b1;
      tick();
      bus8.i_ready = 1'b0;
      check({tag, "_ready_after"}, 32'(bus8.o_ready), 32'd1);
      check({tag, "_valid_after"}, 32'(bus8.o_valid), 32'd0);
    end
  endtask

  // Issue one WIDTH=2 request and check the result against the scoreboard.
  task automatic run2(input logic [1:0] a, input logic [1:0] b, input logic c);
    int n;
    logic [2:0] exp;
    logic [2:0] got;
    bus2.i_a     = a;
    bus2.i_b     = b;
    bus2.i_cin   = c;
    bus2.i_valid = 1'b1;
    tick();
    bus2.i_valid = 1'b0;
    q2.push_back(3'(a) + 3'(b) + 3'(c));
    n = 0;
    while (!bus2.o_valid && n < 10) begin
      tick();
      n++;
    end
    if (!bus2.o_valid) begin
      check("w2_timeout", 32'd0, 32'd1);
    end else begin
      check("w2_lat", 32'(n), 32'd2);
      exp = q2.pop_front();
      got = {bus2.o_cout, bus2.o_sum};
      $display("W2 a=%0d b=%0d cin=%0d got=%0d exp=%0d %s",
               a, b, c, got, exp, (got === exp) ? "Correct" : "Wrong");
      check("w2_result", 32'(got), 32'(exp));
      bus2.i_ready = 1'b1;
      tick();
      bus2.i_ready = 1'b0;
    end
  endtask

  initial begin
    int t1;
    int t2;
    int cyc;
    logic busy_prev;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus8.i_valid = 1'b0; bus8.i_ready = 1'b0;
    bus8.i_a = '0; bus8.i_b = '0; bus8.i_cin = 1'b0;
    bus2.i_valid = 1'b0; bus2.i_ready = 1'b0;
    bus2.i_a = '0; bus2.i_b = '0; bus2.i_cin = 1'b0;

    // Reset state.
    #12;
    check("rst_ready", 32'(bus8.o_ready), 32'd1);
    check("rst_valid", 32'(bus8.o_valid), 32'd0);
    check("rst_busy", 32'(bus8.o_busy), 32'd0);
    check("rst_sum", 32'(bus8.o_sum), 32'd0);
    check("rst_cout", 32'(bus8.o_cout), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic sums and latency.
    send8(8'h00, 8'h00, 1'b0);
    collect8("zero", 8, 0);
    send8(8'hFF, 8'h01, 1'b0);
    collect8("ff_01", 8, 0);
    send8(8'hA5, 8'h5A, 1'b1);
    collect8("a5_5a_c", 8, 0);

    // Consumer stall in DONE.
    send8(8'h12, 8'h34, 1'b1);
    collect8("stall", 8, 5);

    // Inputs disturbed during RUN must be ignored.
    send8(8'h3C, 8'h0F, 1'b0);
    bus8.i_a = 8'hFF; bus8.i_b = 8'hFF; bus8.i_cin = 1'b1;
    bus8.i_valid = 1'b1;
    repeat (3) tick();
    bus8.i_valid = 1'b0;
    collect8("disturb", 5, 0);
    tick();
    check("no_queue_busy", 32'(bus8.o_busy), 32'd0);
    check("no_queue_ready", 32'(bus8.o_ready), 32'd1);

    // Reset after bit 3 aborts the operation.
    send8(8'h80, 8'h80, 1'b0);
    repeat (4) tick();
    check("pre_abort_busy", 32'(bus8.o_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(bus8.o_ready), 32'd1);
    check("abort_valid", 32'(bus8.o_valid), 32'd0);
    check("abort_busy", 32'(bus8.o_busy), 32'd0);
    check("abort_sum", 32'(bus8.o_sum), 32'd0);
    check("abort_cout", 32'(bus8.o_cout), 32'd0);
    q8.delete();
    tick();
    rst = 1'b0;
    tick();
    send8(8'h80, 8'h80, 1'b0);
    collect8("after_abort", 8, 0);

    // Reset while a result is waiting in DONE.
    send8(8'h7F, 8'h01, 1'b0);
    cyc = 0;
    while (!bus8.o_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("done_valid", 32'(bus8.o_valid), 32'd1);
    check("done_sum", 32'(bus8.o_sum), 32'h80);
    rst = 1'b1;
    #1;
    check("done_abort_valid", 32'(bus8.o_valid), 32'd0);
    check("done_abort_sum", 32'(bus8.o_sum), 32'd0);
    check("done_abort_ready", 32'(bus8.o_ready), 32'd1);
    q8.delete();
    tick();
    rst = 1'b0;
    tick();

    // Issue interval with both sides always willing.
    bus8.i_a = 8'h01; bus8.i_b = 8'h02; bus8.i_cin = 1'b0;
    bus8.i_valid = 1'b1;
    bus8.i_ready = 1'b1;
    t1 = -100;
    t2 = -1;
    busy_prev = bus8.o_busy;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus8.o_busy && !busy_prev) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
      busy_prev = bus8.o_busy;
    end
    check("issue_interval", 32'(t2 - t1), 32'd10);
    bus8.i_valid = 1'b0;
    repeat (12) tick();
    bus8.i_ready = 1'b0;
    check("interval_idle", 32'(bus8.o_ready), 32'd1);

    // WIDTH=2 exhaustive.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          run2(2'(a), 2'(b), 1'(c));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port i_valid, input, 1 bit, operand request.
REQ-005 SHALL have port o_ready, output, 1 bit, block can accept operands.
REQ-006 SHALL have port i_a, input, WIDTH bits, operand A.
REQ-007 SHALL have port i_b, input, WIDTH bits, operand B.
REQ-008 SHALL have port i_cin, input, 1 bit, carry-in.
REQ-009 SHALL have port o_valid, output, 1 bit, result available.
REQ-010 SHALL have port i_ready, input, 1 bit, consumer accepts result.
REQ-011 SHALL have port o_sum, output, WIDTH bits, (A+B+cin) mod 2^WIDTH.
REQ-012 SHALL have port o_cout, output, 1 bit, carry out of bit WIDTH-1.
REQ-013 SHALL have port o_busy, output, 1 bit, high in RUN state.

Function
REQ-014 SHALL compute the sum bit-serially with exactly one full-adder cell (half-adder pair plus OR) and a 1-bit carry register, LSB first.
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 In IDLE: o_ready=1, o_valid=0, o_busy=0.
REQ-017 IDLE->RUN on an edge with i_valid=1: capture i_a and i_b into shift registers, load the carry register from i_cin, clear the bit counter and the sum register.
REQ-018 In RUN: o_ready=0, o_busy=1; at each edge, process bit k with sum_k = a_k^b_k^c and c <= majority(a_k,b_k,c); shift the operands right; shift sum_k into the sum register MSB; increment the counter.
REQ-019 RUN->DONE on the edge that processes bit WIDTH-1; o_valid is therefore first high WIDTH cycles after the accept edge.
REQ-020 In DONE: o_valid=1; o_sum and o_cout hold stable until the handshake completes.
REQ-021 DONE->IDLE on an edge with i_ready=1; the result is dropped, and o_sum/o_cout keep their last values until the next accept.
REQ-022 Inputs i_a, i_b, i_cin and i_valid SHALL be ignored outside IDLE; no request is queued.
REQ-023 Minimum issue interval SHALL be WIDTH+2 cycles with i_valid and i_ready held high.
REQ-024 WIDTH=1 SHALL work: RUN lasts one cycle.
REQ-025 The counter SHALL be $clog2(WIDTH+1) bits wide and never wrap during RUN.
REQ-026 o_ready, o_valid and o_busy SHALL be decoded from registered state only, with no combinational path from inputs.

Reset
REQ-027 Asserting reset SHALL immediately force state IDLE, o_valid=0, o_busy=0 and o_ready=1.
REQ-028 Asserting reset SHALL immediately clear o_sum, o_cout, the carry register, the counter and the operand registers.
REQ-029 Reset mid-RUN or in DONE SHALL abort the operation with no result presented; the first request after release SHALL complete correctly.

Verification (WIDTH=8 unless stated)
REQ-030 Bench SHALL cover: A=0x00, B=0x00, cin=0 -> o_valid high 8 cycles after accept, o_sum=0x00, o_cout=0.
REQ-031 Bench SHALL cover: A=0xFF, B=0x01, cin=0 -> o_sum=0x00, o_cout=1; then A=0xA5, B=0x5A, cin=1 -> o_sum=0x00, o_cout=1.
REQ-032 Bench SHALL cover: hold i_ready=0 for 5 cycles in DONE -> o_valid stays 1, o_sum/o_cout unchanged, o_ready=0; i_ready=1 -> o_ready=1 the next cycle.
REQ-033 Bench SHALL cover: change i_a/i_b and pulse i_valid during RUN -> result still matches the originally captured operands (0x3C+0x0F -> 0x4B, cout 0).
REQ-034 Bench SHALL cover: assert reset after bit 3 of 0x80+0x80 -> outputs zero and o_ready=1 at once; next request 0x80+0x80 -> o_sum=0x00, o_cout=1.
REQ-035 Bench SHALL cover: WIDTH=2, all 32 combinations of A, B and cin -> {o_cout,o_sum}=A+B+cin, printed as Correct/Wrong per case.
